// File: rtl/jx2_ic_tile_c.sv
// Direct-mapped 16-byte-line instruction tile cache, even/odd banked so a fetch window may straddle two lines.
// Optional next-line prefetch on hits is enabled by defining JX2_ICTILE_PREFETCH_EN.
module jx2_ic_tile_c #(
  parameter int ICLINES = 8,
  parameter int PADDR_W = 48
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [63:0]  regInPc,
  input  logic         regInFlush,
  output logic [47:0]  regOutPcVal,
  output logic [1:0]   regOutPcOK,
  output logic [1:0]   regOutPcStep,
  input  logic [127:0] memPcData,
  input  logic [1:0]   memPcOK,
  output logic [47:0]  memPcAddr,
  output logic [4:0]   memPcOpm
);
  localparam logic [1:0] UMEM_OK_OK       = 2'b01;
  localparam logic [1:0] UMEM_OK_HOLD     = 2'b10;
  localparam logic [4:0] UMEM_OPM_READY   = 5'h00;
  localparam logic [4:0] UMEM_OPM_RD_TILE = 5'h07;

  localparam int IDX_W  = $clog2(ICLINES);
  localparam int LINE_W = PADDR_W - 4;
  localparam int TAG_W  = LINE_W - IDX_W;
  localparam int BANK_N = ICLINES / 2;
  localparam int BANK_W = (IDX_W > 1) ? IDX_W - 1 : 1;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  function automatic logic [BANK_W-1:0] bankEnt(input logic [LINE_W-1:0] a);
    logic [IDX_W-1:0] i;
    i = a[IDX_W-1:0] >> 1;
    return i[BANK_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] lineTag(input logic [LINE_W-1:0] a);
    return a[LINE_W-1:IDX_W];
  endfunction

  logic [127:0]     evData [BANK_N];
  logic [127:0]     odData [BANK_N];
  logic [TAG_W-1:0] evTag  [BANK_N];
  logic [TAG_W-1:0] odTag  [BANK_N];
  logic [BANK_N-1:0] evValid, odValid;

  state_t            state, stateNxt;
  logic [LINE_W-1:0] reqLine, reqLineNxt;
  logic              flushSeen, flushSeenNxt;
  logic [127:0]      fillData;

  // Line L and L+1 always differ in index parity, so each bank serves exactly one of them.
  // L+1 is a full line-address increment, which carries into the tag on index wrap.
  logic [LINE_W-1:0] lineL, lineN, lineEv, lineOd;
  logic [BANK_W-1:0] evEnt, odEnt, wrEnt;
  logic              evHit, odHit, hitL, hitN, needN, arrHit;
  logic [127:0]      dataL, dataN;
  logic [255:0]      pairWin, shiftWin;

  assign lineL  = regInPc[PADDR_W-1:4];
  assign lineN  = lineL + 1'b1;
  assign lineEv = lineL[0] ? lineN : lineL;
  assign lineOd = lineL[0] ? lineL : lineN;
  assign evEnt  = bankEnt(lineEv);
  assign odEnt  = bankEnt(lineOd);
  assign wrEnt  = bankEnt(reqLine);

  assign evHit  = evValid[evEnt] && (evTag[evEnt] == lineTag(lineEv));
  assign odHit  = odValid[odEnt] && (odTag[odEnt] == lineTag(lineOd));
  assign hitL   = lineL[0] ? odHit : evHit;
  assign hitN   = lineL[0] ? evHit : odHit;
  assign dataL  = lineL[0] ? odData[odEnt] : evData[evEnt];
  assign dataN  = lineL[0] ? evData[evEnt] : odData[odEnt];
  assign needN  = regInPc[3:1] > 3'd5;
  assign arrHit = hitL && (!needN || hitN);

  assign pairWin     = {dataN, dataL};
  assign shiftWin    = pairWin >> {regInPc[3:1], 4'b0000};
  assign regOutPcVal = shiftWin[47:0];
  assign regOutPcOK  = (arrHit && !regInFlush) ? UMEM_OK_OK : UMEM_OK_HOLD;

  always_comb begin
    regOutPcStep = 2'b00;
    if (regOutPcOK == UMEM_OK_OK) begin
      if (regOutPcVal[15:10] == 6'b111111)
        regOutPcStep = 2'b11;
      else if (regOutPcVal[15:12] == 4'b1111)
        regOutPcStep = 2'b10;
      else
        regOutPcStep = 2'b01;
    end
  end

  always_comb begin
    stateNxt     = state;
    reqLineNxt   = reqLine;
    flushSeenNxt = flushSeen | regInFlush;
    memPcOpm     = UMEM_OPM_READY;
    memPcAddr    = '0;
    case (state)
      IDLE: begin
        flushSeenNxt = 1'b0;
        if (!hitL) begin
          stateNxt   = REQ;
          reqLineNxt = lineL;
        end else if (needN && !hitN) begin
          stateNxt   = REQ;
          reqLineNxt = lineN;
        end
`ifdef JX2_ICTILE_PREFETCH_EN
        else if (!hitN && !regInFlush) begin
          stateNxt   = REQ;
          reqLineNxt = lineN;
        end
`endif
      end
      REQ: begin
        memPcOpm                = UMEM_OPM_RD_TILE;
        memPcAddr[PADDR_W-1:4]  = reqLine;
        if (memPcOK == UMEM_OK_OK)
          stateNxt = FILL;
      end
      FILL:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      reqLine   <= '0;
      flushSeen <= 1'b0;
    end else begin
      state     <= stateNxt;
      reqLine   <= reqLineNxt;
      flushSeen <= flushSeenNxt;
    end
  end

  // A flush anywhere in the transaction leaves the filled line invalid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      evValid <= '0;
      odValid <= '0;
    end else if (regInFlush) begin
      evValid <= '0;
      odValid <= '0;
    end else if (state == FILL && !flushSeen) begin
      if (reqLine[0]) odValid[wrEnt] <= 1'b1;
      else            evValid[wrEnt] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (state == REQ && memPcOK == UMEM_OK_OK)
      fillData <= memPcData;
    if (state == FILL) begin
      if (reqLine[0]) begin
        odData[wrEnt] <= fillData;
        odTag[wrEnt]  <= lineTag(reqLine);
      end else begin
        evData[wrEnt] <= fillData;
        evTag[wrEnt]  <= lineTag(reqLine);
      end
    end
  end

  logic unusedPc;
  assign unusedPc = ^{regInPc[63:PADDR_W], regInPc[0]};
endmodule

// File: tb/tb_jx2_ic_tile_c.sv
// Bench for jx2_ic_tile_c: resident-line set model plus memory image, directed literals then random fetch/flush.
`timescale 1ns/1ps
module tb_jx2_ic_tile_c;
  localparam int ICL = 4;
  localparam logic [1:0] OK_READY = 2'b00, OK_OK = 2'b01, OK_HOLD = 2'b10;
  localparam logic [4:0] OPM_READY = 5'h00, OPM_RD = 5'h07;
  localparam longint LMASK = (64'd1 << 44) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [63:0]  regInPc = 64'h1000;
  logic         regInFlush = 1'b0;
  logic [47:0]  regOutPcVal;
  logic [1:0]   regOutPcOK, regOutPcStep;
  logic [127:0] memPcData = '0;
  logic [1:0]   memPcOK = OK_READY;
  logic [47:0]  memPcAddr;
  logic [4:0]   memPcOpm;

  int nTests = 0, nFail = 0;
  int fixedWait = 0;

  always #5 clock = ~clock;

  jx2_ic_tile_c #(.ICLINES(ICL), .PADDR_W(48)) dut (
    .clock(clock), .reset(reset), .regInPc(regInPc), .regInFlush(regInFlush),
    .regOutPcVal(regOutPcVal), .regOutPcOK(regOutPcOK), .regOutPcStep(regOutPcStep),
    .memPcData(memPcData), .memPcOK(memPcOK), .memPcAddr(memPcAddr), .memPcOpm(memPcOpm)
  );

  logic [127:0] memImg [longint];

  function automatic logic [127:0] memLine(input longint ln);
    logic [31:0] a;
    if (memImg.exists(ln)) return memImg[ln];
    a = ln[31:0];
    return {a * 32'h9E3779B1, (a * 32'h85EBCA6B) ^ 32'h12345678,
            (a * 32'hC2B2AE35) + 32'h0F0F0F0F, (a * 32'h27D4EB2F) ^ 32'hDEADBEEF};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory: answers each tile read after fixedWait cycles (random 0..3 when negative).
  int  waitLeft = 0;
  bit  busy = 0;
  always @(posedge clock) begin
    #1;
    if (memPcOpm == OPM_RD) begin
      if (!busy) begin
        busy = 1;
        waitLeft = (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 3));
      end
      if (waitLeft == 0) begin
        memPcOK   = OK_OK;
        memPcData = memLine(longint'(memPcAddr[47:4]));
        busy      = 0;
      end else begin
        waitLeft--;
        memPcOK   = OK_HOLD;
        memPcData = {$urandom, $urandom, $urandom, $urandom};
      end
    end else begin
      busy      = 0;
      memPcOK   = OK_READY;
      memPcData = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Model: set of resident lines, direct mapped by line mod ICL; a line becomes resident one
  // edge after its handshake unless a flush was seen while its request was open.
  longint     resident [longint];
  bit         pendFill = 0, pendFlushed = 0, prevRd = 0, prevAck = 0;
  longint     pendLine = 0, prevCand = -1;
  logic [47:0] prevAddr = '0, prevPc = '1;
  int         streak = 0;

  function automatic bit isRes(input longint ln);
    return resident.exists(ln % ICL) && resident[ln % ICL] == ln;
  endfunction

  always @(negedge clock) begin
    logic [47:0]  pc, expVal;
    logic [255:0] pair;
    logic [1:0]   expStep;
    logic [15:0]  w;
    longint       ln, nl, cand;
    int           off;
    bit           inL, inN, need, expOk, rd, ack;
    if (!reset) begin
      resident.delete();
      pendFill = 0; pendFlushed = 0; prevRd = 0; prevAck = 0; prevCand = -1; streak = 0; prevPc = '1;
    end else begin
      pc    = regInPc[47:0];
      ln    = longint'(pc[47:4]);
      nl    = (ln + 1) & LMASK;
      off   = int'(pc[3:1]);
      inL   = isRes(ln);
      inN   = isRes(nl);
      need  = off > 5;
      expOk = !regInFlush && inL && (!need || inN);
      check("pcOK", regOutPcOK, expOk ? OK_OK : OK_HOLD);
      expStep = 2'b00;
      if (expOk) begin
        pair   = {memLine(nl), memLine(ln)};
        pair   = pair >> (off * 16);
        expVal = pair[47:0];
        w      = expVal[15:0];
        if (w[15:10] == 6'b111111) expStep = 2'b11;
        else if (w[15:10] == 6'b111110 || w[15:11] == 5'b11110) expStep = 2'b10;
        else expStep = 2'b01;
        check("pcVal", regOutPcVal, expVal);
      end
      check("pcStep", regOutPcStep, expStep);

      rd  = memPcOpm == OPM_RD;
      ack = rd && memPcOK == OK_OK;
      if (!rd) check("opmIdle", memPcOpm, OPM_READY);
      else begin
        check("addrAlign", memPcAddr[3:0], 4'h0);
        if (prevRd && !prevAck) check("addrStable", memPcAddr, prevAddr);
        if (!prevRd) check("reqLine", longint'(memPcAddr[47:4]), prevCand);
      end

      cand = -1;
      if (!inL) cand = ln;
      else if (need && !inN) cand = nl;
`ifdef JX2_ICTILE_PREFETCH_EN
      else if (expOk && !inN) cand = nl;
`endif

      if (pc == prevPc && !regInFlush && !expOk) streak++;
      else streak = 0;
      if (streak == 30) check("liveness", 1'b0, 1'b1);

      if (regInFlush) resident.delete();
      if (pendFill) begin
        if (!pendFlushed && !regInFlush) resident[pendLine % ICL] = pendLine;
        pendFill = 0;
        pendFlushed = 0;
      end else if (rd) begin
        pendFlushed = pendFlushed | regInFlush;
        if (ack) begin
          pendFill = 1;
          pendLine = longint'(memPcAddr[47:4]);
        end
      end
      prevRd = rd; prevAck = ack; prevAddr = memPcAddr; prevCand = cand; prevPc = pc;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic waitOk(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clock);
    while (regOutPcOK !== OK_OK && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, regOutPcOK, OK_OK);
  endtask

  task automatic waitRd(input string name, input logic [47:0] addr, input int budget);
    int n;
    n = 0;
    while (memPcOpm !== OPM_RD && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, memPcAddr, addr);
  endtask

  task automatic waitRdDone(input int budget);
    int n;
    n = 0;
    while (memPcOpm === OPM_RD && n < budget) begin
      @(negedge clock);
      n++;
    end
  endtask

  logic [1:0] stepTab [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    memImg[64'h100] = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    memImg[64'h101] = 128'h11112222_33334444_55556666_77775A5A;
    memImg[64'h102] = 128'h11112222_33334444_3000F400_F800FC00;
    memImg[64'h103] = 128'hCAFEBABE_0000_1111_2222_3333_4444_5555;
    memImg[64'h104] = 128'h99998888_77776666_55554444_3333BEEF;
    stepTab[0] = 2'b11; stepTab[1] = 2'b10; stepTab[2] = 2'b10; stepTab[3] = 2'b01;

    // reset state
    repeat (2) @(negedge clock);
    check("rstOK", regOutPcOK, OK_HOLD);
    check("rstOpm", memPcOpm, OPM_READY);
    check("rstAddr", memPcAddr, 48'h0);

    // first fill: detect, REQ, FILL, hit on cycle 3
    fixedWait = 0;
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("c0Hold", regOutPcOK, OK_HOLD);
    @(negedge clock);
    check("c1Opm", memPcOpm, OPM_RD);
    check("c1Addr", memPcAddr, 48'h1000);
    @(negedge clock);
    check("c2Hold", regOutPcOK, OK_HOLD);
    @(negedge clock);
    check("c3OK", regOutPcOK, OK_OK);
    check("c3Val", regOutPcVal, 48'hBA9876543210);

    // window straddling into the next line
    tick();
    regInPc = 64'h100C;
`ifndef JX2_ICTILE_PREFETCH_EN
    waitRd("secondFill", 48'h1010, 10);
`endif
    waitOk("crossOK", 15);
    check("crossVal", regOutPcVal, 48'h5A5A01234567);

    // length predecode
    for (int k = 0; k < 4; k++) begin
      tick();
      regInPc = 64'h1020 + 64'(2 * k);
      waitOk("stepOK", 15);
      check("stepLit", regOutPcStep, stepTab[k]);
    end

    // flush while a request is open
    fixedWait = 3;
    tick();
    regInPc = 64'h2000;
    @(negedge clock);
    waitRd("flushReq", 48'h2000, 10);
    tick();
    regInFlush = 1'b1;
    @(negedge clock);
    check("flushHold", regOutPcOK, OK_HOLD);
    tick();
    regInFlush = 1'b0;
    @(negedge clock);
    waitRdDone(10);
    @(negedge clock);
    check("reMissHold", regOutPcOK, OK_HOLD);
    fixedWait = 0;
    waitRd("refetch", 48'h2000, 10);
    waitOk("refetchOK", 15);
    tick();
    regInPc = 64'h1020;
    @(negedge clock);
    check("flushedMiss", regOutPcOK, OK_HOLD);

    // window across index wrap 3 -> 0
    tick();
    regInPc = 64'h103C;
    waitOk("wrapOK", 30);
    check("wrapVal", regOutPcVal, 48'hBEEFCAFEBABE);

`ifdef JX2_ICTILE_PREFETCH_EN
    tick();
    regInFlush = 1'b1;
    tick();
    regInFlush = 1'b0;
    regInPc = 64'h1000;
    waitOk("pfBaseOK", 15);
    waitRd("pfReq", 48'h1010, 10);
    waitRdDone(10);
    tick();
    regInPc = 64'h1010;
    @(negedge clock);
    check("pfHit", regOutPcOK, OK_OK);
`endif

    // reset mid-request abandons the fill
    fixedWait = 3;
    tick();
    regInPc = 64'h1050;
    @(negedge clock);
    waitRd("rstReq", 48'h1050, 10);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("midRstOpm", memPcOpm, OPM_READY);
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("midRstMiss", regOutPcOK, OK_HOLD);
    fixedWait = -1;

    // random fetch/flush traffic
    for (int it = 0; it < 400; it++) begin
      int sel, hold;
      logic [47:0] base;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       base = 48'h1000;
        1:       base = 48'h2000;
        2:       base = 48'h1040;
        default: base = 48'hFFFF_FFFF_FFC0;
      endcase
      regInPc = {16'($urandom), base + 48'($urandom_range(0, 63))};
      hold = ($urandom_range(0, 7) == 0) ? 35 : int'($urandom_range(1, 6));
      for (int h = 0; h < hold; h++) begin
        regInFlush = ($urandom_range(0, 49) == 0);
        tick();
      end
      regInFlush = 1'b0;
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/jx2_ic_tile_c.md
JX2_IC_TILE_C -- requirements
Module: Jx2IcTileC

Interface
REQ-001 SHALL have parameter ICLINES, default 8, number of 128-bit lines; power of two, minimum 2.
REQ-002 SHALL have parameter PADDR_W, default 48, physical PC width in bits.
REQ-003 SHALL have ports: clock  in  1  sole clock, rising-edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: regInPc  in  64  fetch PC; bits [PADDR_W-1:0] used, bit 0 ignored.
REQ-006 SHALL have ports: regInFlush  in  1  invalidate all lines.
REQ-007 SHALL have ports: regOutPcVal  out  48  fetch window starting at PC.
REQ-008 SHALL have ports: regOutPcOK  out  2  UMEM_OK_OK on hit, UMEM_OK_HOLD on miss or flush.
REQ-009 SHALL have ports: regOutPcStep  out  2  predecoded length of the first op, in 16-bit words.
REQ-010 SHALL have ports: memPcData  in  128  fill data.
REQ-011 SHALL have ports: memPcOK  in  2  memory status, UMEM_OK_* codes.
REQ-012 SHALL have ports: memPcAddr  out  48  line request address, 16-byte aligned.
REQ-013 SHALL have ports: memPcOpm  out  5  UMEM_OPM_RD_TILE while requesting, else UMEM_OPM_READY.

Function
REQ-014 SHALL implement a direct-mapped cache of 16-byte lines: index = PC[4+log2(ICLINES)-1:4]; tag = PC[PADDR_W-1:4+log2(ICLINES)]; one valid bit per line.
REQ-015 SHALL store lines in two banks, even and odd index, so line L and line L+1 are looked up in the same cycle.
REQ-016 SHALL declare a hit when line L hits and, if PC[3:1] > 5, line L+1 also hits; window crossing index wrap from ICLINES-1 to 0 SHALL use the incremented tag.
REQ-017 On a hit, regOutPcVal SHALL equal the 48 bits at byte offset PC[3:1]*2 of the concatenation {lineL+1, lineL}, combinationally in the same cycle.
REQ-018 regOutPcStep SHALL decode the first 16-bit word w: w[15:10]=111111 -> 2'b11; 111110 or 11110x -> 2'b10; else 2'b01. On a miss it SHALL be 2'b00.
REQ-019 SHALL use miss FSM states IDLE, REQ, FILL.
REQ-020 IDLE -> REQ when a miss is seen; the missing line SHALL be latched, line L taking priority over L+1.
REQ-021 In REQ, memPcAddr SHALL be the latched line address with memPcOpm = RD_TILE, held stable until memPcOK == UMEM_OK_OK.
REQ-022 On memPcOK == UMEM_OK_OK, SHALL capture memPcData and go to FILL.
REQ-023 FILL SHALL write data, tag and valid, drive memPcOpm = READY, then return to IDLE, which re-evaluates the current PC.
REQ-024 A PC change during REQ SHALL NOT abort the request; the latched line SHALL be filled.
REQ-025 regInFlush SHALL clear all valid bits next edge and force regOutPcOK = HOLD that cycle.
REQ-026 A flush arriving during REQ or FILL SHALL let the transaction finish but SHALL suppress setting valid for that line.
REQ-027 Minimum miss-to-hit latency SHALL be 3 cycles plus memory wait: detect, REQ, FILL, hit. A two-line miss SHALL serialise two fills.

Reset
REQ-028 While reset is low: all valid bits 0, FSM in IDLE, memPcOpm = UMEM_OPM_READY, memPcAddr = 0; regOutPcOK therefore reads HOLD.
REQ-029 Reset asserted mid-transaction SHALL abandon it without writing the array; line data and tags need no reset.

Configuration
REQ-030 With JX2_ICTILE_PREFETCH_EN defined, an IDLE cycle on a hit where line L+1 is invalid or has the wrong tag SHALL launch a REQ/FILL for line L+1; a demand miss arriving during a prefetch SHALL wait for it to finish.
REQ-031 Without JX2_ICTILE_PREFETCH_EN, only demand misses SHALL generate requests.

Verification
REQ-032 After reset, PC=0x1000 -> HOLD; RD_TILE at 0x1000; memPcOK=OK with data D -> OK and regOutPcVal=D[47:0] on cycle 3.
REQ-033 Line 0x1000 resident, PC=0x100C -> second fill at 0x1010 issued; then window = {L1[15:0], L0[127:96]}.
REQ-034 Step decode: first word 0xFC00 -> 2'b11; 0xF800 -> 2'b10; 0xF400 -> 2'b10; 0x3000 -> 2'b01.
REQ-035 Flush during REQ for 0x2000: fill completes, then PC=0x2000 misses again; all prior lines miss.
REQ-036 ICLINES=4: PC=0x103C with lines 0x1030 and 0x1040 resident -> hit across the index wrap.
REQ-037 With prefetch enabled: hit at 0x1000 with no other lines -> RD_TILE 0x1010 issued unprompted; PC 0x1010 then hits.
